// File: rtl/loop.sv
// -----------------------------------------------------------------------------
// loop -- handshake liveness / heartbeat block
//
// Purpose:
//   An internal initiator and an internal responder run a continuous 4-phase
//   req/rsp handshake. Each completed handshake pulses `done`. A watchdog
//   counts the cycles since the last `done`. The registered `ack` output
//   reports that the loop is alive and is still completing handshakes.
//
// Ports:
//   clk  in   1  clock, all state updates on the rising edge
//   rst  in   1  asynchronous, active-low reset (rst=0 clears all state at once)
//   ack  out  1  loop-alive flag, registered
//
// Parameters:
//   RESP_DELAY  cycles the responder waits after seeing req=1 before it
//               raises rsp (legal range 1..7)
//   WDOG_LIMIT  maximum cycles between completions before ack drops
//   CNT_W       width of the completed-handshake counter (wraps)
//
// Handshake contract (4-phase, both wires registered):
//   The initiator raises req and holds it until it sees rsp=1. It then drops
//   req and waits for rsp=0, which completes one handshake. The responder
//   raises rsp RESP_DELAY cycles after it sees req=1 and holds rsp until it
//   sees req=0. Neither side looks at its own output, and each side reacts
//   only to the other side's flop. So the loop has no combinational cycle.
//   The period is RESP_DELAY+5 cycles.
// -----------------------------------------------------------------------------
module loop #(
    parameter int RESP_DELAY = 2,
    parameter int WDOG_LIMIT = 12,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst,
    output logic ack
);

    // Initiator states
    localparam logic [1:0] I_IDLE = 2'd0;
    localparam logic [1:0] I_REQ  = 2'd1;
    localparam logic [1:0] I_DROP = 2'd2;

    // Responder states
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_ACK  = 2'd2;

    // The watchdog only needs to reach WDOG_LIMIT, because it saturates there.
    localparam int              WD_W      = $clog2(WDOG_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_MAX    = WD_W'(WDOG_LIMIT);
    localparam logic [2:0]      DCNT_LAST = 3'(RESP_DELAY - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       i_state_q, i_state_d;
    logic             req_q, req_d;
    logic             done_q, done_d;

    logic [1:0]       r_state_q, r_state_d;
    logic             rsp_q, rsp_d;
    logic [2:0]       dcnt_q, dcnt_d;

    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [CNT_W-1:0] hs_count_q, hs_count_d;
    logic             ack_q, ack_d;

    // This is the responder's rsp as the initiator sees it. It is a separate
    // net, so the rsp path into the initiator has one clear observation point.
    logic             rsp_line;
    assign rsp_line = rsp_q;

    // -------------------------------------------------------------------------
    // Initiator
    // -------------------------------------------------------------------------
    always_comb begin
        i_state_d = i_state_q;
        req_d     = req_q;
        done_d    = 1'b0;
        case (i_state_q)
            I_IDLE: begin
                i_state_d = I_REQ;
                req_d     = 1'b1;
            end
            I_REQ: begin
                req_d = 1'b1;
                if (rsp_line) begin
                    i_state_d = I_DROP;
                    req_d     = 1'b0;
                end
            end
            I_DROP: begin
                req_d = 1'b0;
                if (!rsp_line) begin
                    i_state_d = I_IDLE;
                    done_d    = 1'b1;
                end
            end
            default: begin
                // An unused encoding goes back to idle with req low.
                i_state_d = I_IDLE;
                req_d     = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Responder
    // -------------------------------------------------------------------------
    always_comb begin
        r_state_d = r_state_q;
        rsp_d     = rsp_q;
        dcnt_d    = dcnt_q;
        case (r_state_q)
            R_IDLE: begin
                rsp_d = 1'b0;
                if (req_q) begin
                    r_state_d = R_WAIT;
                    dcnt_d    = 3'd0;
                end
            end
            R_WAIT: begin
                rsp_d = 1'b0;
                if (dcnt_q == DCNT_LAST) begin
                    r_state_d = R_ACK;
                    rsp_d     = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 3'd1;
                end
            end
            R_ACK: begin
                rsp_d = 1'b1;
                if (!req_q) begin
                    r_state_d = R_IDLE;
                    rsp_d     = 1'b0;
                end
            end
            default: begin
                r_state_d = R_IDLE;
                rsp_d     = 1'b0;
                dcnt_d    = 3'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Completion counter, watchdog and alive flag.
    // These all react to the registered done pulse.
    // -------------------------------------------------------------------------
    always_comb begin
        hs_count_d = hs_count_q;
        if (done_q) begin
            // Wraps silently at 2^CNT_W.
            hs_count_d = hs_count_q + 1'b1;
        end
    end

    always_comb begin
        wdog_d = wdog_q;
        if (done_q) begin
            wdog_d = '0;
        end else if (wdog_q != WD_MAX) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_comb begin
        ack_d = ack_q;
        // A completion takes priority over an expired watchdog in the same cycle.
        if (done_q) begin
            ack_d = 1'b1;
        end else if (wdog_q == WD_MAX) begin
            ack_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_state_q  <= I_IDLE;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            r_state_q  <= R_IDLE;
            rsp_q      <= 1'b0;
            dcnt_q     <= 3'd0;
            wdog_q     <= '0;
            hs_count_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            i_state_q  <= i_state_d;
            req_q      <= req_d;
            done_q     <= done_d;
            r_state_q  <= r_state_d;
            rsp_q      <= rsp_d;
            dcnt_q     <= dcnt_d;
            wdog_q     <= wdog_d;
            hs_count_q <= hs_count_d;
            ack_q      <= ack_d;
        end
    end

    assign ack = ack_q;

endmodule

// File: tb/tb_loop.sv
// -----------------------------------------------------------------------------
// tb_loop -- self-checking bench for the loop heartbeat block.
//
// Two instances run from the same clock and reset:
//   dut  : default parameters (period 7, watchdog 12)
//   dut7 : RESP_DELAY=7 (period 12, watchdog 12)
//
// The bench predicts the done pulses from the period. For each predicted
// completion it pushes the expected hs_count into exp_q. A monitor pops one
// entry for each done pulse the DUT actually produces.
// -----------------------------------------------------------------------------
module tb_loop;

    localparam int P_DEF = 7;     // RESP_DELAY(2) + 5
    localparam int P_7   = 12;    // RESP_DELAY(7) + 5
    localparam int RUN   = 1900;  // long enough for hs_count to wrap past 255

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ack;
    logic ack7;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic       sb_en     = 1'b0;
    logic       prev_done = 1'b0;
    int         model_cnt = 0;

    loop #(.RESP_DELAY(2), .WDOG_LIMIT(12), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .ack (ack)
    );

    loop #(.RESP_DELAY(7), .WDOG_LIMIT(12), .CNT_W(8)) dut7 (
        .clk (clk),
        .rst (rst),
        .ack (ack7)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    // hs_count becomes valid one edge after done_q, so the compare happens on
    // the falling edge that follows the falling edge where done was seen.
    always @(negedge clk) begin
        if (!sb_en) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("hs_count", 32'(dut.hs_count_q), 32'(exp_q.pop_front()));
                end
            end
            prev_done = dut.done_q;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int  ok;
        int  waited;

        // 1. Hold reset for 10 cycles.
        rst = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            check("rst_ack", 32'(ack), 32'd0);
            check("rst_hs_count", 32'(dut.hs_count_q), 32'd0);
        end

        // 2 + 3 + 6. Release reset and run both instances.
        @(posedge clk); #1;
        rst       = 1'b1;
        model_cnt = 0;
        exp_q.delete();
        sb_en     = 1'b1;
        for (int n = 1; n <= RUN; n++) begin
            @(posedge clk); #1;
            if (n <= P_DEF) check("ack_early", 32'(ack), 32'd0);
            if (n == 8)     check("ack_cycle8", 32'(ack), 32'd1);
            if (n == 16)    check("ack_cycle16", 32'(ack), 32'd1);
            if (n % 15 == 0) check("ack_sample", 32'(ack), 32'd1);
            check("done_timing", 32'(dut.done_q), 32'(n % P_DEF == 0));
            if (n % P_DEF == 0) begin
                model_cnt++;
                exp_q.push_back(8'(model_cnt));
            end
            check("done7_timing", 32'(dut7.done_q), 32'(n % P_7 == 0));
            if (n <= P_7) check("ack7_early", 32'(ack7), 32'd0);
            else          check("ack7_alive", 32'(ack7), 32'd1);
        end
        @(posedge clk); #1;
        check("hs_count_wrap", 32'(dut.hs_count_q), 32'(8'(RUN / P_DEF)));
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        sb_en = 1'b0;

        // 4. Hold the responder's rsp low as the initiator sees it.
        force dut.rsp_line = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("ack_wdog_drop", 32'(ack), 32'd0);
        release dut.rsp_line;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (ack === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check("ack_recover", 32'(ok), 32'd1);

        // 5. Asynchronous reset while the initiator sits in I_REQ.
        ok     = 0;
        waited = 0;
        while (!ok && waited < 20) begin
            @(posedge clk); #1;
            waited++;
            if (dut.i_state_q == 2'd1) ok = 1;
        end
        check("reach_i_req", 32'(ok), 32'd1);
        check("ack_before_rst", 32'(ack), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("async_ack", 32'(ack), 32'd0);
        check("async_req", 32'(dut.req_q), 32'd0);
        check("async_rsp", 32'(dut.rsp_q), 32'd0);
        check("async_hs_count", 32'(dut.hs_count_q), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            check("restart_done", 32'(dut.done_q), 32'(n == P_DEF));
            check("restart_ack", 32'(ack), 32'(n >= 8));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
